execute_sequencer: RTL and testbench
====================================

// Module: execute_sequencer
// PURPOSE
//  Sequences the EX stage: forwarding-mux selects for the ALU operands and load-use stall/bubble control.
//  Also holds EX for multi-cycle ALU ops and applies branch-redirect flushes.
//  Sits between the decode/execute/memory/writeback pipeline registers and the execute stage.
//  Drives pipeline-register enables and flushes plus execute-stage operand selects.
// PARAMETERS
//  MULTI_LATENCY  4   EX occupancy in cycles of a multi-cycle op; legal range 2..16
//  REG_ADDR_W     5   register-index width
//  CNT_W          16  width of the stall-cycle counter
// PORTS
//  clk             in   1           system clock, rising edge
//  rst             in   1           asynchronous reset, active-high
//  rs1_id, rs2_id  in   REG_ADDR_W  source registers of the instruction in ID
//  rs1_ex, rs2_ex  in   REG_ADDR_W  source registers of the instruction in EX
//  rd_ex           in   REG_ADDR_W  destination register in EX
//  ex_mem_read     in   1           EX instruction is a load
//  ex_reg_write    in   1           EX instruction writes rd_ex
//  rd_mem          in   REG_ADDR_W  destination register in MEM
//  mem_reg_write   in   1           MEM instruction writes rd_mem
//  rd_wb           in   REG_ADDR_W  destination register in WB
//  wb_reg_write    in   1           WB instruction writes rd_wb
//  ex_multi_start  in   1           EX holds a multi-cycle op this cycle
//  branch_taken    in   1           EX resolved a taken branch or jump
//  forward_a       out  2           left-operand select: 00 reg file, 10 MEM result, 01 WB result
//  forward_b       out  2           right-operand select, same encoding as forward_a
//  stall_if        out  1           hold PC
//  stall_id        out  1           hold the IF/ID register
//  stall_ex        out  1           hold the ID/EX register and the EX operands
//  flush_id        out  1           clear the IF/ID register
//  flush_ex        out  1           insert a bubble into ID/EX
//  ex_busy         out  1           multi-cycle op in progress
//  ex_done         out  1           one-cycle pulse when a multi-cycle op completes
//  stall_cycles    out  CNT_W       saturating count of cycles with stall_if=1
// BEHAVIOUR
//  Reset (async, rst=1): state=RUN, cnt=0, stall_cycles=0.
//   While rst=1, every control output is forced to 0 regardless of inputs.
//  Forwarding (combinational):
//   forward_a=10 if mem_reg_write && rd_mem!=0 && rd_mem==rs1_ex;
//   else 01 if wb_reg_write && rd_wb!=0 && rd_wb==rs1_ex; else 00.
//   MEM has priority over WB. forward_b uses the same rule on rs2_ex.
//  load_use = ex_mem_read && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id).
//  FSM states: RUN, MULTI.
//  RUN:
//   - branch_taken: flush_id=1, flush_ex=1, no stall. This has highest priority and masks load_use and ex_multi_start.
//   - else ex_multi_start: go to MULTI, cnt<=MULTI_LATENCY-2. Assert stall_if/id/ex and ex_busy in this same cycle.
//   - else load_use: stall_if=1, stall_id=1, flush_ex=1 for this cycle only; state stays RUN.
//     Re-evaluated next cycle, when the load has moved to MEM and the hazard has cleared.
//  MULTI:
//   - stall_if/id/ex=1 and ex_busy=1; cnt decrements each cycle.
//   - At cnt==0: ex_done=1, stall_* and ex_busy=0 in this cycle, next state RUN.
//     Total EX occupancy is MULTI_LATENCY cycles.
//   - branch_taken, load_use and ex_multi_start are ignored in MULTI.
//  stall_cycles increments on every cycle with stall_if=1 and holds at 2^CNT_W-1.
//  rst asserted mid-MULTI: returns to RUN immediately; no ex_done pulse is issued.
// CONFIGURATION
//  Macro EXEC_FORWARDING_EN.
//  Defined: forwarding exactly as described under BEHAVIOUR.
//  Undefined: forward_a and forward_b are constant 00. The RUN stall condition widens to raw_hazard:
//   raw_hazard = (ex_reg_write && rd_ex!=0 && rd_ex matches rs1_id or rs2_id)
//             || (mem_reg_write && rd_mem!=0 && rd_mem matches rs1_id or rs2_id).
//   raw_hazard is handled like load_use (stall_if/id + flush_ex) and repeats each cycle until clear.
//   Priority is unchanged: branch_taken > ex_multi_start > raw_hazard.
// TESTING
//  1. rd_mem=5, mem_reg_write=1, rd_wb=5, wb_reg_write=1, rs1_ex=5 -> forward_a=10.
//     Same case with mem_reg_write=0 -> forward_a=01. rd_mem=0 -> no forwarding from MEM.
//  2. Load to x3 in EX, rs2_id=3 -> exactly one cycle of stall_if=stall_id=flush_ex=1.
//     stall_cycles increments by 1.
//  3. ex_multi_start=1 with MULTI_LATENCY=4 -> stall_* and ex_busy high for 3 cycles.
//     Then ex_done=1 for 1 cycle, then RUN.
//  4. branch_taken=1 together with load_use=1 -> flush_id=flush_ex=1, stall_if=0, state stays RUN.
//  5. rst pulsed during cycle 2 of MULTI -> all outputs 0 asynchronously.
//     After release: RUN, no ex_done pulse.
//  6. Without EXEC_FORWARDING_EN: ALU writing x7 in EX, rs1_id=7 -> stall for 2 cycles until rd_mem clears.
//     forward_a and forward_b stay 00 throughout.

Source files
------------

// File: rtl/execute_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// execute_sequencer
//
// Purpose:
//   Sequences the EX stage of the pipeline. It selects forwarding sources for
//   the two ALU operands, stalls and bubbles on read-after-write hazards, holds
//   EX for multi-cycle ALU ops and flushes IF/ID and ID/EX on a branch redirect.
//
// Configuration macro: EXEC_FORWARDING_EN
//   defined   - MEM/WB forwarding is active and only load-use hazards stall.
//   undefined - forward_a/forward_b are constant 00, and any RAW hazard against
//               EX or MEM stalls until the producer has left MEM.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   rs1_id, rs2_id           source registers of the instruction in ID
//   rs1_ex, rs2_ex, rd_ex    source and destination registers in EX
//   ex_mem_read              EX instruction is a load
//   ex_reg_write             EX instruction writes rd_ex
//   rd_mem, mem_reg_write    MEM destination register and its write enable
//   rd_wb, wb_reg_write      WB destination register and its write enable
//   ex_multi_start           EX holds a multi-cycle op this cycle
//   branch_taken             EX resolved a taken branch or jump
//   forward_a, forward_b     operand selects: 00 reg file, 10 MEM, 01 WB
//   stall_if/id/ex           hold PC / IF/ID / ID/EX and EX operands
//   flush_id, flush_ex       clear IF/ID / insert a bubble into ID/EX
//   ex_busy, ex_done         multi-cycle op in progress / completion pulse
//   stall_cycles             saturating count of cycles with stall_if=1
// -----------------------------------------------------------------------------
module execute_sequencer #(
  parameter int MULTI_LATENCY = 4,
  parameter int REG_ADDR_W    = 5,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic [REG_ADDR_W-1:0] rs1_ex,
  input  logic [REG_ADDR_W-1:0] rs2_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  wb_reg_write,
  input  logic                  ex_multi_start,
  input  logic                  branch_taken,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  ex_busy,
  output logic                  ex_done,
  output logic [CNT_W-1:0]      stall_cycles
);

  // Counter only ever holds MULTI_LATENCY-2 down to 0.
  localparam int LAT_W = (MULTI_LATENCY > 2) ? $clog2(MULTI_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MULTI_LATENCY - 2);

  typedef enum logic {ST_RUN, ST_MULTI} state_t;

  state_t             r_state, w_state_next;
  logic [LAT_W-1:0]   r_cnt, w_cnt_next;
  logic [CNT_W-1:0]   r_stall_cycles;

  logic [1:0]         w_fwd_a, w_fwd_b;
  logic               w_load_use, w_hazard;
  logic               w_stall_if, w_stall_id, w_stall_ex;
  logic               w_flush_id, w_flush_ex, w_busy, w_done;

  assign w_load_use = ex_mem_read && (rd_ex != '0) &&
                      ((rd_ex == rs1_id) || (rd_ex == rs2_id));

`ifdef EXEC_FORWARDING_EN
  logic w_unused_fwd;
  assign w_unused_fwd = ex_reg_write;

  // MEM result is younger than WB, so it wins when both match.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (mem_reg_write && (rd_mem != '0) && (rd_mem == rs1_ex))
      w_fwd_a = 2'b10;
    else if (wb_reg_write && (rd_wb != '0) && (rd_wb == rs1_ex))
      w_fwd_a = 2'b01;
    if (mem_reg_write && (rd_mem != '0) && (rd_mem == rs2_ex))
      w_fwd_b = 2'b10;
    else if (wb_reg_write && (rd_wb != '0) && (rd_wb == rs2_ex))
      w_fwd_b = 2'b01;
  end

  assign w_hazard = w_load_use;
`else
  logic w_unused_fwd;
  logic w_raw_hazard;
  assign w_unused_fwd = ^{rs1_ex, rs2_ex, rd_wb, wb_reg_write};

  assign w_fwd_a = 2'b00;
  assign w_fwd_b = 2'b00;

  // Without bypass paths the ID instruction must wait until every in-flight
  // producer in EX or MEM has reached WB (the register file write-through
  // covers the WB stage).
  assign w_raw_hazard =
      (ex_reg_write  && (rd_ex  != '0) && ((rd_ex  == rs1_id) || (rd_ex  == rs2_id))) ||
      (mem_reg_write && (rd_mem != '0) && ((rd_mem == rs1_id) || (rd_mem == rs2_id)));

  assign w_hazard = w_raw_hazard || w_load_use;
`endif

  // Next-state and control decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall_if   = 1'b0;
    w_stall_id   = 1'b0;
    w_stall_ex   = 1'b0;
    w_flush_id   = 1'b0;
    w_flush_ex   = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (branch_taken) begin
          // Redirect wins: the younger instructions are discarded anyway,
          // so any hazard or multi-cycle request they raise is moot.
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
        end else if (ex_multi_start) begin
          w_state_next = ST_MULTI;
          w_cnt_next   = LAT_LOAD;
          w_stall_if   = 1'b1;
          w_stall_id   = 1'b1;
          w_stall_ex   = 1'b1;
          w_busy       = 1'b1;
        end else if (w_hazard) begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_flush_ex = 1'b1;
        end
      end
      ST_MULTI: begin
        if (r_cnt == '0) begin
          // Final occupancy cycle: release the pipe while pulsing done.
          w_done       = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
          w_busy     = 1'b1;
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_stall_if && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Reset masks every control output combinationally so the pipeline is
  // quiet for the whole time rst is high, not just after the next edge.
  assign forward_a    = rst ? 2'b00 : w_fwd_a;
  assign forward_b    = rst ? 2'b00 : w_fwd_b;
  assign stall_if     = w_stall_if & ~rst;
  assign stall_id     = w_stall_id & ~rst;
  assign stall_ex     = w_stall_ex & ~rst;
  assign flush_id     = w_flush_id & ~rst;
  assign flush_ex     = w_flush_ex & ~rst;
  assign ex_busy      = w_busy & ~rst;
  assign ex_done      = w_done & ~rst;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_execute_sequencer.sv
`timescale 1ns/1ps
module tb_execute_sequencer;

  localparam int RW = 5;
  localparam int CW = 4;
`ifdef EXEC_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic          ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write;
  logic          ex_multi_start, branch_taken;
  logic [1:0]    forward_a, forward_b;
  logic          stall_if, stall_id, stall_ex, flush_id, flush_ex, ex_busy, ex_done;
  logic [CW-1:0] stall_cycles;

  // Order: stall_if, stall_id, stall_ex, flush_id, flush_ex, ex_busy, ex_done
  logic [6:0] ctrl;
  assign ctrl = {stall_if, stall_id, stall_ex, flush_id, flush_ex, ex_busy, ex_done};

  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_HAZ   = 7'b1100100;
  localparam logic [6:0] C_MULTI = 7'b1110010;
  localparam logic [6:0] C_DONE  = 7'b0000001;
  localparam logic [6:0] C_BR    = 7'b0001100;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stalls = 0;

  always #5 clk = ~clk;

  execute_sequencer #(.MULTI_LATENCY(4), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .rd_mem(rd_mem), .mem_reg_write(mem_reg_write),
    .rd_wb(rd_wb), .wb_reg_write(wb_reg_write),
    .ex_multi_start(ex_multi_start), .branch_taken(branch_taken),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex),
    .ex_busy(ex_busy), .ex_done(ex_done), .stall_cycles(stall_cycles)
  );

  task automatic clear_inputs();
    rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0;
    rd_ex = '0; rd_mem = '0; rd_wb = '0;
    ex_mem_read = 0; ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_multi_start = 0; branch_taken = 0;
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 3ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    branch_taken = 1; ex_mem_read = 1; rd_ex = 3; rs1_id = 3;
    rd_mem = 5; mem_reg_write = 1; rs1_ex = 5;
    tick(); #2;
    n_checks++;
    if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_IDLE); end
    n_checks++;
    if (forward_a !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a got=%b exp=00", forward_a); end
    n_checks++;
    if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
    clear_inputs();
    tick();
    rst = 1'b0;
    exp_stalls = 0;
    $display("reset: ctrl=%b fwd_a=%b stall_cycles=%0d", ctrl, forward_a, stall_cycles);
  endtask

  task automatic test_forwarding();
    logic [1:0] ea, eb;
    for (int v = 0; v < 4; v++) begin
      tick(); clear_inputs();
      case (v)
        0: begin rd_mem = 5; mem_reg_write = 1; rd_wb = 5; wb_reg_write = 1; rs1_ex = 5;
                 ea = FWD ? 2'b10 : 2'b00; eb = 2'b00; end
        1: begin rd_mem = 5; mem_reg_write = 0; rd_wb = 5; wb_reg_write = 1; rs1_ex = 5;
                 ea = FWD ? 2'b01 : 2'b00; eb = 2'b00; end
        2: begin rd_mem = 0; mem_reg_write = 1; rd_wb = 0; wb_reg_write = 1; rs1_ex = 0;
                 ea = 2'b00; eb = 2'b00; end
        default: begin rd_mem = 9; mem_reg_write = 0; rd_wb = 9; wb_reg_write = 1;
                 rs2_ex = 9; rs1_ex = 4; ea = 2'b00; eb = FWD ? 2'b01 : 2'b00; end
      endcase
      #2;
      n_checks++;
      if (forward_a !== ea) begin n_fail++; $display("FAIL fwd_a_v%0d got=%b exp=%b", v, forward_a, ea); end
      n_checks++;
      if (forward_b !== eb) begin n_fail++; $display("FAIL fwd_b_v%0d got=%b exp=%b", v, forward_b, eb); end
      $display("forward v%0d: fwd_a=%b fwd_b=%b", v, forward_a, forward_b);
    end
    tick(); clear_inputs();
  endtask

  task automatic test_load_use();
    // Cycle 1: load to x3 in EX, ID reads x3.
    tick(); clear_inputs();
    ex_mem_read = 1; ex_reg_write = 1; rd_ex = 3; rs1_id = 1; rs2_id = 3;
    #2;
    n_checks++;
    if (ctrl !== C_HAZ) begin n_fail++; $display("FAIL load_use_c1 got=%b exp=%b", ctrl, C_HAZ); end
    exp_stalls++;
    // Cycle 2: load moved to MEM, EX holds the bubble.
    tick(); clear_inputs();
    rd_mem = 3; mem_reg_write = 1; rs1_id = 1; rs2_id = 3;
    #2;
    n_checks++;
    if (ctrl !== (FWD ? C_IDLE : C_HAZ)) begin
      n_fail++; $display("FAIL load_use_c2 got=%b exp=%b", ctrl, (FWD ? C_IDLE : C_HAZ));
    end
    if (!FWD) exp_stalls++;
    tick(); clear_inputs(); #2;
    n_checks++;
    if (stall_cycles !== CW'(exp_stalls)) begin
      n_fail++; $display("FAIL load_use_count got=%0d exp=%0d", stall_cycles, exp_stalls);
    end
    $display("load_use: stall_cycles=%0d", stall_cycles);
  endtask

  task automatic test_multi();
    logic [6:0] exp_c [5];
    exp_c[0] = C_MULTI; exp_c[1] = C_MULTI; exp_c[2] = C_MULTI;
    exp_c[3] = C_DONE;  exp_c[4] = C_IDLE;
    for (int c = 0; c < 5; c++) begin
      tick(); clear_inputs();
      if (c == 0) ex_multi_start = 1;
      // Redirect and load-use inside MULTI must be ignored.
      if (c == 1) begin branch_taken = 1; ex_mem_read = 1; rd_ex = 2; rs1_id = 2; end
      #2;
      n_checks++;
      if (ctrl !== exp_c[c]) begin n_fail++; $display("FAIL multi_c%0d got=%b exp=%b", c, ctrl, exp_c[c]); end
      $display("multi c%0d: ctrl=%b", c, ctrl);
    end
    exp_stalls += 3;
    n_checks++;
    if (stall_cycles !== CW'(exp_stalls)) begin
      n_fail++; $display("FAIL multi_count got=%0d exp=%0d", stall_cycles, exp_stalls);
    end
  endtask

  task automatic test_branch();
    tick(); clear_inputs();
    branch_taken = 1; ex_multi_start = 1;
    ex_mem_read = 1; ex_reg_write = 1; rd_ex = 3; rs2_id = 3;
    #2;
    n_checks++;
    if (ctrl !== C_BR) begin n_fail++; $display("FAIL branch_c1 got=%b exp=%b", ctrl, C_BR); end
    tick(); clear_inputs(); #2;
    n_checks++;
    if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL branch_stays_run got=%b exp=%b", ctrl, C_IDLE); end
    n_checks++;
    if (stall_cycles !== CW'(exp_stalls)) begin
      n_fail++; $display("FAIL branch_count got=%0d exp=%0d", stall_cycles, exp_stalls);
    end
    $display("branch: ctrl=%b stall_cycles=%0d", ctrl, stall_cycles);
  endtask

  task automatic test_raw();
    // ALU op writing x7 in EX, ID reads x7.
    tick(); clear_inputs();
    ex_reg_write = 1; rd_ex = 7; rs1_id = 7;
    #2;
    n_checks++;
    if (ctrl !== (FWD ? C_IDLE : C_HAZ)) begin
      n_fail++; $display("FAIL raw_c1 got=%b exp=%b", ctrl, (FWD ? C_IDLE : C_HAZ));
    end
    if (!FWD) exp_stalls++;
    tick(); clear_inputs();
    mem_reg_write = 1; rd_mem = 7; rs1_id = 7;
    #2;
    n_checks++;
    if (ctrl !== (FWD ? C_IDLE : C_HAZ)) begin
      n_fail++; $display("FAIL raw_c2 got=%b exp=%b", ctrl, (FWD ? C_IDLE : C_HAZ));
    end
    n_checks++;
    if ({forward_a, forward_b} !== 4'b0000) begin
      n_fail++; $display("FAIL raw_fwd got=%b%b exp=0000", forward_a, forward_b);
    end
    if (!FWD) exp_stalls++;
    tick(); clear_inputs(); rs1_id = 7;
    #2;
    n_checks++;
    if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL raw_c3 got=%b exp=%b", ctrl, C_IDLE); end
    n_checks++;
    if (stall_cycles !== CW'(exp_stalls)) begin
      n_fail++; $display("FAIL raw_count got=%0d exp=%0d", stall_cycles, exp_stalls);
    end
    $display("raw: stall_cycles=%0d", stall_cycles);
  endtask

  task automatic test_reset_mid_multi();
    tick(); clear_inputs(); ex_multi_start = 1;
    tick(); clear_inputs();           // MULTI cycle 1
    tick();                           // MULTI cycle 2
    #1; rst = 1'b1; #1;
    n_checks++;
    if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL mid_rst_async got=%b exp=%b", ctrl, C_IDLE); end
    n_checks++;
    if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL mid_rst_count got=%0d exp=0", stall_cycles); end
    #1; rst = 1'b0;
    exp_stalls = 0;
    for (int c = 0; c < 4; c++) begin
      tick(); #2;
      n_checks++;
      if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL mid_rst_after_c%0d got=%b exp=%b", c, ctrl, C_IDLE); end
    end
    $display("reset_mid_multi: ctrl=%b stall_cycles=%0d", ctrl, stall_cycles);
  endtask

  task automatic test_saturation();
    tick(); clear_inputs();
    ex_mem_read = 1; ex_reg_write = 1; rd_ex = 3; rs1_id = 3;
    for (int c = 0; c < 14; c++) tick();
    #2;
    n_checks++;
    if (stall_cycles !== 4'd14) begin n_fail++; $display("FAIL sat_pre got=%0d exp=14", stall_cycles); end
    for (int c = 0; c < 6; c++) tick();
    #2;
    n_checks++;
    if (stall_cycles !== 4'd15) begin n_fail++; $display("FAIL sat_hold got=%0d exp=15", stall_cycles); end
    n_checks++;
    if (ctrl !== C_HAZ) begin n_fail++; $display("FAIL sat_ctrl got=%b exp=%b", ctrl, C_HAZ); end
    tick(); clear_inputs();
    $display("saturation: stall_cycles=%0d", stall_cycles);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_multi();
    test_branch();
    test_raw();
    test_reset_mid_multi();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
